// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// per-cell next-state select codes and decode helpers.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD    = 3'b000;
  localparam logic [2:0] MODE_SHR     = 3'b001;
  localparam logic [2:0] MODE_SHL     = 3'b010;
  localparam logic [2:0] MODE_LOAD    = 3'b011;
  localparam logic [2:0] MODE_ROR     = 3'b100;
  localparam logic [2:0] MODE_ROL     = 3'b101;
  localparam logic [2:0] MODE_JOHNSON = 3'b110;
  localparam logic [2:0] MODE_RSVD    = 3'b111;

  // from_hi is the neighbour toward the MSB (data moving right),
  // from_lo is the neighbour toward the LSB (data moving left).
  typedef enum logic [1:0] {
    SEL_HOLD    = 2'd0,
    SEL_FROM_HI = 2'd1,
    SEL_FROM_LO = 2'd2,
    SEL_PAR     = 2'd3
  } cell_sel_e;

  function automatic logic is_shift_class(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
           (mode == MODE_ROL) || (mode == MODE_JOHNSON);
  endfunction

  function automatic cell_sel_e mode_to_sel(input logic [2:0] mode);
    cell_sel_e sel;
    sel = SEL_HOLD;
    case (mode)
      MODE_SHR, MODE_ROR, MODE_JOHNSON: sel = SEL_FROM_HI;
      MODE_SHL, MODE_ROL:               sel = SEL_FROM_LO;
      MODE_LOAD:                        sel = SEL_PAR;
      default:                          sel = SEL_HOLD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One register bit: async active-low reset, synchronous preset/clear,
// and a 4:1 next-state mux (hold / MSB-side neighbour / LSB-side neighbour / parallel).
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      preset,
  input  logic      clear,
  input  cell_sel_e sel,
  input  logic      from_hi,
  input  logic      from_lo,
  input  logic      par,
  output logic      q
);

  logic d;

  always_comb begin
    d = q;
    case (sel)
      SEL_HOLD:    d = q;
      SEL_FROM_HI: d = from_hi;
      SEL_FROM_LO: d = from_lo;
      SEL_PAR:     d = par;
      default:     d = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (preset) begin
      q <= 1'b1;
    end else if (clear) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: chain of usr_bit_cell instances with end-of-chain
// feedback selection, plus a modulo-WIDTH shift counter and wrap pulse.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             preset,
  input  logic             clear,
  input  logic [2:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             cycle_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  cell_sel_e sel;
  logic      msb_feed;
  logic      lsb_feed;
  logic      shift_op;
  logic      cnt_wrap;

  assign sel      = mode_to_sel(mode);
  assign shift_op = is_shift_class(mode);
  assign cnt_wrap = (shift_cnt == CNT_MAX);

  // Value entering the MSB cell when data moves right, and the LSB cell when it moves left.
  always_comb begin
    msb_feed = ser_in_r;
    case (mode)
      MODE_ROR:     msb_feed = q[0];
      MODE_JOHNSON: msb_feed = ~q[0];
      default:      msb_feed = ser_in_r;
    endcase
  end

  always_comb begin
    lsb_feed = ser_in_l;
    case (mode)
      MODE_ROL: lsb_feed = q[WIDTH-1];
      default:  lsb_feed = ser_in_l;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic from_hi;
    logic from_lo;

    if (i == WIDTH - 1) begin : g_top
      assign from_hi = msb_feed;
    end else begin : g_mid_hi
      assign from_hi = q[i+1];
    end

    if (i == 0) begin : g_bot
      assign from_lo = lsb_feed;
    end else begin : g_mid_lo
      assign from_lo = q[i-1];
    end

    usr_bit_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .preset  (preset),
      .clear   (clear),
      .sel     (sel),
      .from_hi (from_hi),
      .from_lo (from_lo),
      .par     (par_in[i]),
      .q       (q[i])
    );
  end

  assign ser_out_r = q[0];
  assign ser_out_l = q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_cnt  <= '0;
      cycle_done <= 1'b0;
    end else if (preset || clear || (mode == MODE_LOAD)) begin
      shift_cnt  <= '0;
      cycle_done <= 1'b0;
    end else if (shift_op) begin
      shift_cnt  <= cnt_wrap ? '0 : shift_cnt + 1'b1;
      cycle_done <= cnt_wrap;
    end else begin
      cycle_done <= 1'b0;
    end
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Multi-bit register stage built from a chain of preset/clear D-type cells.
- Consumes parallel or serial data and produces parallel state plus serial taps. Feeds downstream counter and sequence-detector labs.
- Supports hold, shift right/left, parallel load, rotate right/left, and Johnson counting.
- Keeps a shift-operation counter with a wrap pulse.

Parameters:
- WIDTH, 4, number of register bits (min 2).
- CNT_W, $clog2(WIDTH), width of the shift counter (min 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- preset  input  1  synchronous set-all-ones; highest synchronous priority.
- clear  input  1  synchronous clear-all-zeros; below preset.
- mode  input  3  operation select (encoding below).
- ser_in_r  input  1  serial input entering at MSB on shift right.
- ser_in_l  input  1  serial input entering at LSB on shift left.
- par_in  input  WIDTH  parallel load data.
- q  output  WIDTH  register state.
- ser_out_r  output  1  equals q[0] (combinational tap).
- ser_out_l  output  1  equals q[WIDTH-1] (combinational tap).
- shift_cnt  output  CNT_W  count of shift-class operations, modulo WIDTH.
- cycle_done  output  1  registered one-cycle pulse after shift_cnt wraps.

Behaviour:
- Reset: rst_n low asynchronously forces q=0, shift_cnt=0, cycle_done=0, independent of clk.
- Synchronous priority at each posedge: preset > clear > mode.
- preset=1: q=all ones, shift_cnt=0, cycle_done=0.
- clear=1 (preset=0): q=0, shift_cnt=0, cycle_done=0.
- mode encoding, applied only when preset=clear=0:
  - 000 hold: q unchanged.
  - 001 shift right: q <= {ser_in_r, q[WIDTH-1:1]}.
  - 010 shift left: q <= {q[WIDTH-2:0], ser_in_l}.
  - 011 load: q <= par_in; shift_cnt <= 0.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 110 Johnson: q <= {~q[0], q[WIDTH-1:1]}.
  - 111 reserved: behaves as hold.
- Shift-class operations are modes 001, 010, 100 and 101; mode 110 (Johnson) also counts.
- On each shift-class cycle: shift_cnt <= (shift_cnt == WIDTH-1) ? 0 : shift_cnt+1.
- cycle_done <= 1 for exactly the cycle after the wrap from WIDTH-1 to 0; 0 otherwise.
- Hold and reserved modes leave shift_cnt unchanged and clear cycle_done.
- Latency: one clock from control/data sample to q update. Serial taps follow q combinationally.
- Simultaneous preset and clear: preset wins, so q=all ones.
- Reset deasserting mid-operation: first active edge behaves as from q=0, shift_cnt=0.
- No X propagation: every mode value defines a next state.

Decomposition:
- Shared package `usr_pkg`: mode localparams MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_JOHNSON, MODE_RSVD (3-bit).
- One sub-module, `usr_bit_cell`:
  - Single D-type bit with async active-low reset and sync preset/clear.
  - Next-state selected by a 4:1 mux of hold / left neighbour / right neighbour / parallel bit.
  - Instantiated WIDTH times via generate.
- Top level owns neighbour/feedback selection (rotate, Johnson wrap), shift_cnt and cycle_done.

Test Plan (WIDTH=4):
- Async reset and load: rst_n low mid-cycle → q=0000 immediately. Release, then load par_in=1011 → q=1011, shift_cnt=0.
- Shifts: from q=1011, shift right with ser_in_r=0 for 2 cycles → q=0101 then 0010. Next shift left with ser_in_l=1 → q=0101, shift_cnt=3.
- Rotate and wrap: load 1000, then rotate right 4 cycles → q=0100, 0010, 0001, 1000. shift_cnt=1,2,3,0. cycle_done=1 only in the cycle after the 4th rotate.
- Johnson: from q=0000, mode 110 for 8 cycles → q=1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
- Priority: preset=1, clear=1, mode=load, par_in=0000 → q=1111, shift_cnt=0. Then preset=0, clear=1 → q=0000.
- Reserved and hold: q=1010, mode=111 for 3 cycles → q=1010, shift_cnt unchanged, cycle_done=0. ser_out_r=0, ser_out_l=1.
